instr_mem_loadable: RTL

Synchronous, run-time loadable instruction memory for the MIPS single-cycle and pipelined cores. It replaces the fixed combinational instruction ROM with a parametrised RAM. Program images arrive as a byte stream (UART receiver or bench) and are assembled into 32-bit words. The CPU fetch side gets a registered read with a request/valid handshake, NOP substitution for unloaded addresses, and fault reporting for bad addresses.

---
 rtl/instr_mem_loadable.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loadable
// Purpose  : Run-time loadable instruction RAM. A byte stream is packed into
//            words, and the core fetches words with a registered read.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loadable #(
    parameter int          ADDR_BITS  = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [31:0]          fetch_addr,
    output logic                 fetch_ready,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic                 fetch_fault,
    input  logic                 load_start,
    input  logic [ADDR_BITS:0]   load_words,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 load_busy,
    output logic                 load_done,
    output logic [ADDR_BITS:0]   loaded_words
);

    localparam int                   c_DEPTH_N = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   c_DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   c_CNT_ONE = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] c_PTR_ONE = (ADDR_BITS)'(1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_mem [c_DEPTH_N];
    logic [31:0]            r_instr;
    logic                   r_instr_valid;
    logic                   r_fetch_fault;
    logic                   r_load_done;
    logic [ADDR_BITS:0]     r_loaded_words;
    logic [ADDR_BITS:0]     r_target;
    logic [ADDR_BITS-1:0]   r_wptr;
    logic [1:0]             r_bcnt;
    logic [23:0]            r_asm;

    logic [31:0]            w_word;
    logic [23:0]            w_asm_keep;
    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_misaligned;
    logic                   w_out_of_range;
    logic                   w_fault;
    logic                   w_in_loaded;
    logic [ADDR_BITS:0]     w_target;
    logic [ADDR_BITS:0]     w_loaded_inc;
    logic                   w_we;

    // Only three earlier bytes need to be held; the fourth completes the word.
    generate
        if (BIG_ENDIAN) begin : g_big_endian
            assign w_word     = {r_asm, byte_in};
            assign w_asm_keep = w_word[23:0];
        end else begin : g_little_endian
            assign w_word     = {byte_in, r_asm};
            assign w_asm_keep = w_word[31:8];
        end
    endgenerate

    assign w_idx          = fetch_addr[ADDR_BITS+1:2];
    assign w_misaligned   = |fetch_addr[1:0];
    assign w_out_of_range = |fetch_addr[31:ADDR_BITS+2];
    assign w_fault        = w_misaligned | w_out_of_range;
    assign w_in_loaded    = ({1'b0, w_idx} < r_loaded_words);
    assign w_target       = (load_words > c_DEPTH) ? c_DEPTH : load_words;
    assign w_loaded_inc   = r_loaded_words + c_CNT_ONE;
    assign w_we           = reset && (r_state == S_LOAD) && byte_valid && (r_bcnt == 2'd3);

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_RUN;
            r_instr        <= NOP_WORD;
            r_instr_valid  <= 1'b0;
            r_fetch_fault  <= 1'b0;
            r_load_done    <= 1'b0;
            r_loaded_words <= '0;
            r_target       <= '0;
            r_wptr         <= '0;
            r_bcnt         <= 2'd0;
            r_asm          <= '0;
        end else begin
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_load_done   <= 1'b0;
            case (r_state)
                S_RUN: begin
                    // A fetch accepted on the load_start edge still sees the old image.
                    if (fetch_req) begin
                        r_instr_valid <= 1'b1;
                        r_fetch_fault <= w_fault;
                        r_instr       <= (w_fault || !w_in_loaded) ? NOP_WORD : r_mem[w_idx];
                    end
                    if (load_start && (load_words != '0)) begin
                        r_state        <= S_LOAD;
                        r_loaded_words <= '0;
                        r_wptr         <= '0;
                        r_bcnt         <= 2'd0;
                        r_target       <= w_target;
                    end
                end
                S_LOAD: begin
                    if (byte_valid) begin
                        r_asm <= w_asm_keep;
                        if (r_bcnt == 2'd3) begin
                            r_bcnt         <= 2'd0;
                            r_wptr         <= r_wptr + c_PTR_ONE;
                            r_loaded_words <= w_loaded_inc;
                            if (w_loaded_inc == r_target) begin
                                r_state     <= S_RUN;
                                r_load_done <= 1'b1;
                            end
                        end else begin
                            r_bcnt <= r_bcnt + 2'd1;
                        end
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign fetch_ready  = (r_state == S_RUN);
    assign load_busy    = (r_state == S_LOAD);
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign fetch_fault  = r_fetch_fault;
    assign load_done    = r_load_done;
    assign loaded_words = r_loaded_words;

endmodule
`default_nettype wire
